// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths, ALU opcodes and arbiter state encoding.
// Revision    : 1.0
// ============================================================================
package alu_pkg;

    localparam int WIDTH = 64;
    localparam int OPW   = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_AND = 4'd2;
    localparam logic [OPW-1:0] OP_OR  = 4'd3;
    localparam logic [OPW-1:0] OP_XOR = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ALU.sv
`default_nettype none
// ============================================================================
// Module      : ALU
// Description : Shared combinational ALU; undefined opcodes yield zero.
// Revision    : 1.0
// ============================================================================
module ALU #(
    parameter int WIDTH = 64,
    parameter int OPW   = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] F,
    output logic             Z
);
    import alu_pkg::*;

    always_comb begin
        F = '0;
        case (op)
            OP_ADD:  F = A + B;
            OP_SUB:  F = A - B;
            OP_AND:  F = A & B;
            OP_OR:   F = A | B;
            OP_XOR:  F = A ^ B;
            default: F = '0;
        endcase
    end

    assign Z = (F == '0);

endmodule
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin grant; a lone valid always wins.
// Revision    : 1.0
// ============================================================================
module rr_arb2 (
    input  logic v0,
    input  logic v1,
    input  logic last,
    output logic g0,
    output logic g1
);
    // On a tie the requester that did not win last time is favoured.
    assign g0 = v0 & (~v1 | last);
    assign g1 = v1 & (~v0 | ~last);

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sequencer sharing one ALU between two requesters.
// Revision    : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int OPW   = alu_pkg::OPW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_z
);
    import alu_pkg::*;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic             r_id;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_f;
    logic             r_rsp_z;
    logic             w_g0;
    logic             w_g1;
    logic             w_idle;
    logic [WIDTH-1:0] w_f;
    logic             w_z;

    rr_arb2 u_rr (
        .v0   (req0_valid),
        .v1   (req1_valid),
        .last (r_last),
        .g0   (w_g0),
        .g1   (w_g1)
    );

    // The ALU only ever sees the captured operands, never live requester inputs.
    ALU #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .A  (r_a),
        .B  (r_b),
        .op (r_op),
        .F  (w_f),
        .Z  (w_z)
    );

    assign w_idle     = (r_state == IDLE) && !reset;
    assign req0_ready = w_idle & w_g0;
    assign req1_ready = w_idle & w_g1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_g0 | w_g1) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_f     <= '0;
            r_rsp_z     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_g0 | w_g1) begin
                        r_a    <= w_g1 ? req1_a  : req0_a;
                        r_b    <= w_g1 ? req1_b  : req0_b;
                        r_op   <= w_g1 ? req1_op : req0_op;
                        r_id   <= w_g1;
                        r_last <= w_g1;
                    end
                end
                EXEC: begin
                    r_rsp_f     <= w_f;
                    r_rsp_z     <= w_z;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_f     = r_rsp_f;
    assign rsp_z     = r_rsp_z;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a response scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_op, req1_op;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_z;
    logic [W-1:0] rsp_f;

    typedef struct {
        logic         id;
        logic [W-1:0] f;
        logic         z;
    } exp_t;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        logic [W-1:0] f;
        logic         z;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .OPW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_f      (rsp_f),
        .rsp_z      (rsp_z)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed response must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d f=%0h, expected no response", rsp_id, rsp_f);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", W'(rsp_id), W'(e.id));
                chk("rsp_f", rsp_f, e.f);
                chk("rsp_z", W'(rsp_z), W'(e.z));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 30 && sb.size() != 0; n++) begin
            @(negedge clk);
            #1;
        end
        chk("drain", W'(sb.size()), '0);
        tick();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_rsp_f", rsp_f, '0);
        chk("rst_id_z", W'({rsp_id, rsp_z}), '0);
        chk("rst_readies", W'({req0_ready, req1_ready}), '0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sb.delete();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op, input logic [W-1:0] ef, input logic ez,
                         input bit lat, output int waited);
        int n;
        bit got;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        got = 1'b0;
        for (n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) got = 1'b1;
        end
        waited = n;
        chk("accept", W'(got), W'(1));
        if (got) sb.push_back('{id, ef, ez});
        tick();
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
        if (lat) begin
            @(negedge clk);
            chk("lat_exec_valid", W'(rsp_valid), '0);
            @(negedge clk);
            chk("lat_resp_valid", W'(rsp_valid), W'(1));
        end
        drain();
    endtask

    vec_t tbl[9];

    initial begin
        int   w;
        int   grants;
        logic gid;

        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   n;
        int   grants;
        logic gid;
        bit   got;

        tbl[0] = '{1'b0, 64'd0,    64'd265, OP_ADD, 64'd265, 1'b0};
        tbl[1] = '{1'b1, 64'd100,  64'd58,  OP_SUB, 64'd42,  1'b0};
        tbl[2] = '{1'b0, 64'hF0,   64'h3C,  OP_AND, 64'h30,  1'b0};
        tbl[3] = '{1'b1, 64'hF0,   64'h0F,  OP_OR,  64'hFF,  1'b0};
        tbl[4] = '{1'b0, 64'hFF,   64'hFF,  OP_XOR, 64'd0,   1'b1};
        tbl[5] = '{1'b1, 64'd5,    64'd5,   OP_SUB, 64'd0,   1'b1};
        tbl[6] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 64'd0, 1'b1};
        tbl[7] = '{1'b0, 64'd0,    64'd0,   OP_ADD, 64'd0,   1'b1};
        tbl[8] = '{1'b1, 64'd0,    64'd1,   OP_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

        rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        do_reset();

        // Single request straight after reset, with latency check.
        issue(1'b0, 64'd0, 64'd265, OP_ADD, 64'd265, 1'b0, 1'b1, w);
        chk("single_first_cycle", W'(w), W'(1));

        // Tie after reset: req0 wins, then req1.
        do_reset();
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd654; req0_op = OP_ADD;
        req1_valid = 1'b1; req1_a = 64'd6; req1_b = 64'd549; req1_op = OP_ADD;
        @(negedge clk);
        chk("tie_ready", W'({req0_ready, req1_ready}), W'(2'b10));
        sb.push_back('{1'b0, 64'd655, 1'b0});
        tick();
        req0_valid = 1'b0;
        drain();
        issue(1'b1, 64'd6, 64'd549, OP_ADD, 64'd555, 1'b0, 1'b0, w);

        // Table of single operations across opcodes and boundaries.
        for (int i = 0; i < 9; i++)
            issue(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].f, tbl[i].z, 1'b0, w);

        // Continuous contention after reset: grants must alternate 0,1,0,1,...
        do_reset();
        req0_valid = 1'b1; req0_a = 64'd10;  req0_b = 64'd0; req0_op = OP_ADD;
        req1_valid = 1'b1; req1_a = 64'd500; req1_b = 64'd0; req1_op = OP_ADD;
        grants = 0;
        for (n = 0; n < 80 && grants < 6; n++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                gid = req1_ready;
                chk("rr_onehot", W'(req0_ready & req1_ready), '0);
                chk("rr_seq", W'(gid), W'(grants % 2));
                sb.push_back('{gid, gid ? req1_a + req1_b : req0_a + req0_b, 1'b0});
                grants++;
                tick();
                if (gid) req1_b = req1_b + 64'd3;
                else     req0_b = req0_b + 64'd7;
            end
        end
        chk("rr_grants", W'(grants), W'(6));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Backpressure: response frozen while rsp_ready is low.
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_a = 64'd9; req1_b = 64'd564; req1_op = OP_ADD;
        got = 1'b0;
        for (n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            got = req1_ready;
        end
        chk("bp_accept", W'(got), W'(1));
        sb.push_back('{1'b1, 64'd573, 1'b0});
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd2; req0_b = 64'd3; req0_op = OP_ADD;
        @(negedge clk);
        chk("bp_exec_readies", W'({req0_ready, req1_ready}), '0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold", {rsp_f[W-4:0], rsp_valid, rsp_id, rsp_z},
                {64'd573, 1'b1, 1'b1, 1'b0} >> 0 == 0 ? '0 : {61'd573, 1'b1, 1'b1, 1'b0});
            chk("bp_readies", W'({req0_ready, req1_ready}), '0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_complete", W'(sb.size()), '0);
        tick();
        chk("bp_idle", W'(rsp_valid), '0);
        issue(1'b0, 64'd2, 64'd3, OP_ADD, 64'd5, 1'b0, 1'b0, w);

        // Reset in EXEC discards the in-flight operation.
        req0_valid = 1'b1; req0_a = 64'd7; req0_b = 64'd8; req0_op = OP_ADD;
        got = 1'b0;
        for (n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            got = req0_ready;
        end
        chk("rx_accept", W'(got), W'(1));
        tick();
        reset      = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("rx_valid0", W'(rsp_valid), '0);
        tick();
        @(negedge clk);
        chk("rx_outputs", {rsp_f[W-4:0], rsp_valid, rsp_id, rsp_z}, '0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rx_no_rsp", W'(rsp_valid), '0);
        end
        tick();
        issue(1'b0, 64'd4, 64'd788, OP_ADD, 64'd792, 1'b0, 1'b1, w);
        chk("rx_next_first_cycle", W'(w), W'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
